// File: rtl/read_iq_pair.sv
// read_iq_pair: assembles interleaved little-endian I/Q byte pairs
// into quantized signed samples written in lockstep to two FIFOs.
module read_iq_pair #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS       = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  in_rd_en,
  input  logic                  in_empty,
  input  logic [7:0]            in_dout,
  output logic                  out_i_wr_en,
  input  logic                  out_i_full,
  output logic [DATA_WIDTH-1:0] out_i_din,
  output logic                  out_q_wr_en,
  input  logic                  out_q_full,
  output logic [DATA_WIDTH-1:0] out_q_din
);

  typedef enum logic [2:0] {
    S_I_LO,
    S_I_HI,
    S_Q_LO,
    S_Q_HI,
    S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [7:0] i_lo_q, i_lo_d;
  logic [7:0] i_hi_q, i_hi_d;
  logic [7:0] q_lo_q, q_lo_d;

  logic [DATA_WIDTH-1:0] i_reg_q, i_reg_d;
  logic [DATA_WIDTH-1:0] q_reg_q, q_reg_d;

  logic pop;
  logic wr;

  function automatic logic [DATA_WIDTH-1:0] quant(
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    logic [DATA_WIDTH-1:0] ext;
    ext = {{(DATA_WIDTH-16){hi[7]}}, hi, lo};
    return ext << BITS;
  endfunction

  always_comb begin
    state_d = state_q;
    i_lo_d  = i_lo_q;
    i_hi_d  = i_hi_q;
    q_lo_d  = q_lo_q;
    i_reg_d = i_reg_q;
    q_reg_d = q_reg_q;
    pop     = !in_empty && (state_q != S_WRITE);
    wr      = 1'b0;
    unique case (state_q)
      S_I_LO: if (pop) begin
        i_lo_d  = in_dout;
        state_d = S_I_HI;
      end
      S_I_HI: if (pop) begin
        i_hi_d  = in_dout;
        state_d = S_Q_LO;
      end
      S_Q_LO: if (pop) begin
        q_lo_d  = in_dout;
        state_d = S_Q_HI;
      end
      S_Q_HI: if (pop) begin
        i_reg_d = quant(i_hi_q, i_lo_q);
        q_reg_d = quant(in_dout, q_lo_q);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        // both FIFOs must have room; never write only one side
        wr = !out_i_full && !out_q_full;
        if (wr) state_d = S_I_LO;
      end
      default: state_d = S_I_LO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_I_LO;
      i_lo_q  <= '0;
      i_hi_q  <= '0;
      q_lo_q  <= '0;
      i_reg_q <= '0;
      q_reg_q <= '0;
    end else begin
      state_q <= state_d;
      i_lo_q  <= i_lo_d;
      i_hi_q  <= i_hi_d;
      q_lo_q  <= q_lo_d;
      i_reg_q <= i_reg_d;
      q_reg_q <= q_reg_d;
    end
  end

  assign in_rd_en    = pop && !reset;
  assign out_i_wr_en = wr && !reset;
  assign out_q_wr_en = wr && !reset;
  assign out_i_din   = i_reg_q;
  assign out_q_din   = q_reg_q;

endmodule

// File: tb/tb_read_iq_pair.sv
// tb_read_iq_pair: randomized scoreboard bench for read_iq_pair.
// Driver feeds a byte FIFO model; monitor pops expected pairs.
module tb_read_iq_pair;

  localparam int DW   = 32;
  localparam int BITS = 10;

  typedef struct {
    int i;
    int q;
  } pair_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_rd_en;
  logic          in_empty;
  logic [7:0]    in_dout;
  logic          out_i_wr_en;
  logic          out_i_full;
  logic [DW-1:0] out_i_din;
  logic          out_q_wr_en;
  logic          out_q_full;
  logic [DW-1:0] out_q_din;

  read_iq_pair #(.DATA_WIDTH(DW), .BITS(BITS)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_rd_en    (in_rd_en),
    .in_empty    (in_empty),
    .in_dout     (in_dout),
    .out_i_wr_en (out_i_wr_en),
    .out_i_full  (out_i_full),
    .out_i_din   (out_i_din),
    .out_q_wr_en (out_q_wr_en),
    .out_q_full  (out_q_full),
    .out_q_din   (out_q_din)
  );

  always #5 clock = ~clock;

  logic [7:0] bq[$];
  pair_t      exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_bytes = 0;
  int n_pops = 0;
  int n_pairs = 0;
  int n_wr = 0;
  int cyc = 0;
  int first_cyc = 0;
  int bidx = 0;
  int gap_len = 0;
  int gap_rem = 0;
  bit pop_seen = 0;
  bit chk_lat = 0;
  bit rand_full = 0;
  bit force_q_full = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: sample is the 16-bit two's complement value times 2^BITS
  task automatic push_pair(input logic [15:0] iv, input logic [15:0] qv);
    pair_t e;
    e.i = int'(shortint'(iv)) * (1 << BITS);
    e.q = int'(shortint'(qv)) * (1 << BITS);
    exp_q.push_back(e);
    bq.push_back(iv[7:0]);
    bq.push_back(iv[15:8]);
    bq.push_back(qv[7:0]);
    bq.push_back(qv[15:8]);
    n_bytes += 4;
    n_pairs++;
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic wait_idle;
    int n = 0;
    while ((bq.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      tick;
      n++;
    end
    check("idle_timeout", n < 3000, 1);
  endtask

  task automatic wait_bq_empty;
    int n = 0;
    while (bq.size() != 0 && n < 200) begin
      tick;
      n++;
    end
    check("drain_timeout", n < 200, 1);
  endtask

  // byte FIFO / output FIFO model, updated just after each edge
  always @(posedge clock) begin
    #1;
    if (pop_seen && bq.size() > 0) begin
      void'(bq.pop_front());
      gap_rem = gap_len;
    end else if (gap_rem > 0) begin
      gap_rem--;
    end
    in_empty   = (bq.size() == 0) || (gap_rem > 0);
    in_dout    = (bq.size() > 0) ? bq[0] : 8'h5A;
    out_i_full = rand_full && ($urandom_range(0, 3) == 0);
    out_q_full = force_q_full || (rand_full && ($urandom_range(0, 3) == 0));
  end

  // monitor: samples mid-cycle, pops the scoreboard on each write
  always @(negedge clock) begin
    pair_t e;
    cyc++;
    if (reset) begin
      check("rd_en_in_reset", in_rd_en, 0);
      pop_seen = 0;
      bidx = 0;
    end else begin
      pop_seen = in_rd_en && !in_empty;
      if (in_rd_en && in_empty)
        check("pop_while_empty", 1, 0);
      if (out_i_wr_en != out_q_wr_en)
        check("wr_lockstep", out_i_wr_en, out_q_wr_en);
      if (out_i_wr_en && (out_i_full || out_q_full))
        check("wr_while_full", 1, 0);
      if (out_i_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("i_data", longint'($signed(out_i_din)), e.i);
          check("q_data", longint'($signed(out_q_din)), e.q);
          if (chk_lat) check("latency", cyc - first_cyc, 4);
          n_wr++;
        end
      end
      if (pop_seen) begin
        if (bidx == 0) first_cyc = cyc;
        bidx = (bidx + 1) % 4;
        n_pops++;
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_empty = 1'b1;
    in_dout = 8'h00;
    out_i_full = 1'b0;
    out_q_full = 1'b0;

    chk_lat = 1;
    push_pair(16'h0001, 16'hFFFF);
    repeat (3) tick;
    reset = 1'b0;
    @(negedge clock);
    check("rst_i_din", out_i_din, 0);
    check("rst_q_din", out_q_din, 0);
    check("rst_wr_en", out_i_wr_en, 0);
    wait_idle;
    chk_lat = 0;

    push_pair(16'h8000, 16'h7FFF);
    push_pair(16'h0000, 16'h0000);
    wait_idle;

    force_q_full = 1;
    push_pair(16'h4321, 16'hA5C3);
    wait_bq_empty;
    push_pair(16'h0F0F, 16'hF0F0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("stall_rd_en", in_rd_en, 0);
      check("stall_wr_en", out_i_wr_en || out_q_wr_en, 0);
      check("stall_i_din", longint'($signed(out_i_din)), exp_q[0].i);
      check("stall_q_din", longint'($signed(out_q_din)), exp_q[0].q);
    end
    force_q_full = 0;
    @(negedge clock);
    check("release_wr", out_i_wr_en && out_q_wr_en, 1);
    wait_idle;

    gap_len = 3;
    for (int k = 0; k < 8; k++)
      push_pair(16'($urandom), 16'($urandom));
    wait_idle;
    gap_len = 0;

    rand_full = 1;
    for (int k = 0; k < 40; k++)
      push_pair(16'($urandom), 16'($urandom));
    wait_idle;
    rand_full = 0;

    push_pair(16'h1111, 16'h2222);
    wait_idle;
    bq.push_back(8'h77);
    bq.push_back(8'h66);
    n_bytes += 2;
    wait_bq_empty;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_i_din", out_i_din, 0);
    check("mid_rst_q_din", out_q_din, 0);
    check("mid_rst_wr_en", out_i_wr_en, 0);
    push_pair(16'h1234, 16'hEDCC);
    wait_idle;

    repeat (3) tick;
    check("total_pops", n_pops, n_bytes);
    check("total_writes", n_wr, n_pairs);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
